// File: rtl/writeback_stage.sv
// Y86-64 writeback stage with the architectural register file.
// Commits W_valE/W_valM and reports the committed status.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic        W_bubble,
  input  logic [1:0]  W_stat,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14,
  output logic [63:0] reg15,
  output logic [1:0]  w_stat
);

  localparam logic [1:0] SAOK  = 2'b00;
  localparam logic [3:0] INOP  = 4'h0;
  localparam logic [3:0] IHALT = 4'h1;

  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  logic        we;

  assign we = rst_n & ~W_bubble
            & (W_stat == SAOK)
            & (W_icode != INOP)
            & (W_icode != IHALT);

  // RNONE (4'hF) never matches an entry, so it never writes.
  // The M port is applied last so it wins on a shared index.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (we && (W_dstE == 4'(i)))
        rf_d[i] = W_valE;
      if (we && (W_dstM == 4'(i)))
        rf_d[i] = W_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++)
        rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++)
        rf_q[i] <= rf_d[i];
    end
  end

  assign w_stat = (!rst_n || W_bubble) ? SAOK : W_stat;

  assign reg0  = rf_q[0];
  assign reg1  = rf_q[1];
  assign reg2  = rf_q[2];
  assign reg3  = rf_q[3];
  assign reg4  = rf_q[4];
  assign reg5  = rf_q[5];
  assign reg6  = rf_q[6];
  assign reg7  = rf_q[7];
  assign reg8  = rf_q[8];
  assign reg9  = rf_q[9];
  assign reg10 = rf_q[10];
  assign reg11 = rf_q[11];
  assign reg12 = rf_q[12];
  assign reg13 = rf_q[13];
  assign reg14 = rf_q[14];
  assign reg15 = '0;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage.
// Expected register values come from a reference register model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic        W_bubble;
  logic [1:0]  W_stat;
  logic [63:0] r0, r1, r2, r3;
  logic [63:0] r4, r5, r6, r7;
  logic [63:0] r8, r9, r10, r11;
  logic [63:0] r12, r13, r14, r15;
  logic [1:0]  w_stat;

  logic [63:0] obs [16];
  logic [63:0] m [16];

  typedef struct {
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .W_icode  (W_icode),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM),
    .W_bubble (W_bubble),
    .W_stat   (W_stat),
    .reg0     (r0),
    .reg1     (r1),
    .reg2     (r2),
    .reg3     (r3),
    .reg4     (r4),
    .reg5     (r5),
    .reg6     (r6),
    .reg7     (r7),
    .reg8     (r8),
    .reg9     (r9),
    .reg10    (r10),
    .reg11    (r11),
    .reg12    (r12),
    .reg13    (r13),
    .reg14    (r14),
    .reg15    (r15),
    .w_stat   (w_stat)
  );

  always_comb begin
    obs[0]  = r0;
    obs[1]  = r1;
    obs[2]  = r2;
    obs[3]  = r3;
    obs[4]  = r4;
    obs[5]  = r5;
    obs[6]  = r6;
    obs[7]  = r7;
    obs[8]  = r8;
    obs[9]  = r9;
    obs[10] = r10;
    obs[11] = r11;
    obs[12] = r12;
    obs[13] = r13;
    obs[14] = r14;
    obs[15] = r15;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, o, e);
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx = i;
      e.val = m[i];
      q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("%s_r%0d", tag, e.idx),
          obs[e.idx], e.val);
    end
  endtask

  task automatic step(input string tag,
                      input logic [3:0]  ic,
                      input logic [3:0]  de,
                      input logic [63:0] ve,
                      input logic [3:0]  dm,
                      input logic [63:0] vm,
                      input logic        bub,
                      input logic [1:0]  st);
    logic [1:0] es;
    @(negedge clk);
    W_icode  = ic;
    W_dstE   = de;
    W_valE   = ve;
    W_dstM   = dm;
    W_valM   = vm;
    W_bubble = bub;
    W_stat   = st;
    #1;
    es = bub ? 2'b00 : st;
    chk({tag, "_wstat"}, 64'(w_stat), 64'(es));
    if (!bub && st == 2'b00 &&
        ic != 4'h0 && ic != 4'h1) begin
      if (de != 4'hF) m[de] = ve;
      if (dm != 4'hF) m[dm] = vm;
    end
    push_all();
    @(posedge clk);
    #1;
    drain(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = '0;
    rst_n    = 1'b0;
    W_icode  = 4'h2;
    W_dstE   = 4'h3;
    W_valE   = 64'h77;
    W_dstM   = 4'h5;
    W_valM   = 64'h99;
    W_bubble = 1'b0;
    W_stat   = 2'b11;
    #1;
    chk("rst_wstat", 64'(w_stat), 64'd0);
    @(posedge clk);
    #1;
    push_all();
    drain("rst");
    @(negedge clk);
    W_bubble = 1'b1;
    W_stat   = 2'b00;
    rst_n    = 1'b1;

    step("dual", 4'h2, 4'h0, 64'd102,
         4'h1, 64'd55, 1'b0, 2'b00);
    step("mrm", 4'h4, 4'hF, 64'd0,
         4'h9, 64'd87, 1'b0, 2'b00);
    step("popq14", 4'hB, 4'd14, 64'd200,
         4'hF, 64'd0, 1'b0, 2'b00);
    step("bubble", 4'h2, 4'h3, 64'h55,
         4'hF, 64'd0, 1'b1, 2'b01);
    step("adr", 4'h2, 4'h3, 64'h55,
         4'hF, 64'd0, 1'b0, 2'b10);
    step("ins", 4'h5, 4'h6, 64'h66,
         4'h7, 64'h67, 1'b0, 2'b11);
    step("hltst", 4'h2, 4'h8, 64'h88,
         4'hF, 64'd0, 1'b0, 2'b01);
    step("same", 4'hB, 4'h4, 64'd8,
         4'h4, 64'h1234, 1'b0, 2'b00);
    step("none", 4'h6, 4'hF, 64'hABCD,
         4'hF, 64'hEF01, 1'b0, 2'b00);
    step("nop", 4'h0, 4'h2, 64'd7,
         4'hF, 64'd0, 1'b0, 2'b00);
    step("halt", 4'h1, 4'h2, 64'd9,
         4'hF, 64'd0, 1'b0, 2'b00);
    step("icC", 4'hC, 4'hA, 64'hA5,
         4'hF, 64'd0, 1'b0, 2'b00);
    step("wide", 4'h3, 4'h5,
         64'hDEAD_BEEF_CAFE_F00D,
         4'hD, 64'hFFFF_FFFF_FFFF_FFFF,
         1'b0, 2'b00);

    // Reset pulse landing between clock edges.
    @(negedge clk);
    W_stat   = 2'b10;
    W_bubble = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) m[i] = '0;
    chk("midrst_wstat", 64'(w_stat), 64'd0);
    push_all();
    drain("midrst");
    #1;
    rst_n = 1'b1;

    step("resume", 4'h2, 4'h5, 64'h1111,
         4'h6, 64'h2222, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writeback (W) stage of the 5-stage Y86-64 pipeline, including the architectural register file it writes.
- Each clock it commits the W-register results W_valE and W_valM to destination registers W_dstE and W_dstM.
- It exposes all 16 register values for forwarding and debug, and reports the final instruction status (w_stat) to the processor status logic.

Parameters:
- None. Data width is fixed at 64, register count at 16 and register index width at 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- W_icode  input  4  icode of the instruction in W.
- W_valE  input  64  ALU result to write to W_dstE.
- W_valM  input  64  memory read result to write to W_dstM.
- W_dstE  input  4  destination index for valE; 4'hF (RNONE) means no write.
- W_dstM  input  4  destination index for valM; 4'hF (RNONE) means no write.
- W_bubble  input  1  W holds a bubble; suppresses all effects.
- W_stat  input  2  status code: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- reg0..reg15  output  64 each  current register contents (reg4 = %rsp); reg15 is RNONE and is tied to 0.
- w_stat  output  2  committed status.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - reg0..reg14 cleared to 0.
  - reg15 is constant 0.
  - w_stat reads AOK (00) while in reset.
- Write enable: we = rst_n & ~W_bubble & (W_stat == AOK) & (W_icode not NOP 4'h0, not HALT 4'h1).
- On each posedge clk with we=1:
  - If W_dstE != 4'hF: reg[W_dstE] <= W_valE.
  - If W_dstM != 4'hF: reg[W_dstM] <= W_valM.
- Both ports may write in the same cycle to different registers.
- If W_dstE == W_dstM != 4'hF: W_valM wins (popq %rsp semantics).
- Index 4'hF is never written, so reg15 stays 0.
- An X or unknown W_icode outside 0x0..0xB (including 0xC, 0xD) is not special-cased: the dst fields alone decide the writes. Decode supplies RNONE for instructions with no destination.
- Register outputs are the register contents directly, with no combinational bypass. The new value is visible after the clock edge (latency 1 cycle from W inputs to reg outputs).
- w_stat is combinational:
  - W_bubble = 1 gives 00 (AOK).
  - Otherwise w_stat = W_stat.
- No write is performed for a non-AOK status. HLT, ADR and INS leave the register file untouched for that instruction.
- Reset deasserted mid-run: writes resume on the first posedge with rst_n high. A reset asserted between edges clears registers immediately.
- Values are stored full 64-bit, with no truncation or sign handling.

Test Plan:
- Reset then W_icode=2, W_dstE=0, W_valE=102, W_dstM=1, W_valM=55, bubble=0, stat=00, one posedge -> reg0=102, reg1=55, all other regs 0, w_stat=00.
- Then W_icode=4, W_dstM=9, W_valM=87, posedge -> reg9=87, reg0=102 unchanged. Then W_icode=0xB, W_dstE=14, W_valE=200, posedge -> reg14=200.
- W_bubble=1 with W_dstE=3, W_valE=0x55, W_stat=01 -> reg3 unchanged, w_stat=00. Then bubble=0, W_stat=10 -> reg3 unchanged, w_stat=10.
- W_icode=0xB, W_dstE=4, W_valE=8, W_dstM=4, W_valM=0x1234 -> reg4=0x1234. Then W_dstE=4'hF, W_dstM=4'hF, W_icode=6 -> no register changes, reg15=0.
- W_icode=0 (NOP) with W_dstE=2, W_valE=7 -> reg2 unchanged.
- Pull rst_n low between edges after the above -> all regs read 0 immediately; writes resume after release.
